event_latch_arbiter: RTL and testbench

EVENT_LATCH_ARBITER -- requirements
Module: event_latch_arbiter

---
 rtl/event_latch_arbiter.sv | 131 +++++++++++++
 tb/tb_event_latch_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/event_latch_arbiter.sv
// Sticky per-channel event latch with round-robin single-channel offer/handshake.
// Optional saturating overflow counter enabled by defining LATCH_OVF_CNT_EN.
module event_latch_arbiter #(
  parameter int NCH   = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic [NCH-1:0]           evt_in,
  output logic [NCH-1:0]           pending,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic                     out_ovf
`ifdef LATCH_OVF_CNT_EN
  ,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         ovf_cnt
`endif
);

  localparam int CH_W = $clog2(NCH);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state_q, state_d;
  logic [NCH-1:0]    flag_q, flag_d;
  logic [NCH-1:0]    ovf_q, ovf_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [NCH-1:0]    set, clr;
  logic              hs;
  logic [CH_W-1:0]   pick, idx;
  logic              found;
  int                j;

  // Set beats clear on the same channel, and a fresh event there carries no overflow.
  always_comb begin
    set = arm ? evt_in : '0;
    hs  = (state_q == OFFER) && out_ready;
    clr = '0;
    if (hs) clr[out_ch_q] = 1'b1;
    flag_d = set | (flag_q & ~clr);
    ovf_d  = (ovf_q | (set & flag_q)) & ~clr;
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NCH; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NCH) j = j - NCH;
      idx = CH_W'(j);
      if (!found && flag_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    out_ch_d = out_ch_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = OFFER;
          out_ch_d = pick;
        end
      end
      OFFER: begin
        if (out_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (out_ch_q == CH_W'(NCH - 1)) ? '0 : out_ch_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      flag_q   <= '0;
      ovf_q    <= '0;
      rr_ptr_q <= '0;
      out_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      flag_q   <= flag_d;
      ovf_q    <= ovf_d;
      rr_ptr_q <= rr_ptr_d;
      out_ch_q <= out_ch_d;
    end
  end

  assign pending   = flag_q;
  assign out_valid = (state_q == OFFER);
  assign out_ch    = out_ch_q;
  assign out_ovf   = (state_q == OFFER) && ovf_q[out_ch_q];

`ifdef LATCH_OVF_CNT_EN
  localparam int SUM_W = CNT_W + 6;

  logic [NCH-1:0]   ovf_evt;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Sum is wide enough to hold a full counter plus every channel overflowing at once.
  always_comb begin
    ovf_evt = set & flag_q & ~clr;
    sum     = SUM_W'(cnt_q);
    for (int i = 0; i < NCH; i++) sum = sum + SUM_W'(ovf_evt[i]);
    if (cnt_clr)                               cnt_d = '0;
    else if (sum > SUM_W'({CNT_W{1'b1}}))      cnt_d = '1;
    else                                       cnt_d = sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ovf_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_event_latch_arbiter.sv
// Directed bench for event_latch_arbiter (NCH=8); counter checks run when LATCH_OVF_CNT_EN is defined.
module tb_event_latch_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm;
  logic [7:0] evt_in;
  logic [7:0] pending;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_ch;
  logic       out_ovf;
`ifdef LATCH_OVF_CNT_EN
  logic       cnt_clr;
  logic [7:0] ovf_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  event_latch_arbiter #(.NCH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .evt_in    (evt_in),
    .pending   (pending),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_ovf   (out_ovf)
`ifdef LATCH_OVF_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] seq [3];
    seq[0] = 3'd0; seq[1] = 3'd4; seq[2] = 3'd7;

    rst_n = 1'b0; arm = 1'b0; evt_in = '0; out_ready = 1'b0;
`ifdef LATCH_OVF_CNT_EN
    cnt_clr = 1'b0;
`endif
    #12;
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_valid",   32'(out_valid), 32'h0);
    chk("rst_ch",      32'(out_ch), 32'h0);
    chk("rst_ovf",     32'(out_ovf), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single event on channel 2
    arm = 1'b1; out_ready = 1'b1; evt_in = 8'h04;
    tick(); evt_in = '0;
    chk("t1_pending", 32'(pending), 32'h04);
    chk("t1_valid0",  32'(out_valid), 32'h0);
    tick();
    chk("t1_valid1",  32'(out_valid), 32'h1);
    chk("t1_ch",      32'(out_ch), 32'h2);
    chk("t1_ovf",     32'(out_ovf), 32'h0);
    tick();
    chk("t1_drain",   32'(pending), 32'h0);
    chk("t1_idle",    32'(out_valid), 32'h0);

    // Three simultaneous events served round-robin from rr_ptr=0
    do_reset();
    tick();
    evt_in = 8'h91;
    tick(); evt_in = '0;
    chk("t2_pending", 32'(pending), 32'h91);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("t2_valid", 32'(out_valid), 32'h1);
      chk("t2_ch",    32'(out_ch), 32'(seq[s]));
      tick();
      chk("t2_gap",   32'(out_valid), 32'h0);
    end
    chk("t2_empty", 32'(pending), 32'h0);
    evt_in = 8'h03;
    tick(); evt_in = '0;
    tick();
    chk("t2_rr_wrap", 32'(out_ch), 32'h0);
    tick(); tick();
    chk("t2_next",  32'(out_ch), 32'h1);
    tick();
    chk("t2_clean", 32'(pending), 32'h0);

    // Overflow on channel 3 while offered and stalled
    out_ready = 1'b0; evt_in = 8'h08;
    tick(); evt_in = '0;
    tick();
    chk("t3_ch",     32'(out_ch), 32'h3);
    chk("t3_ovf0",   32'(out_ovf), 32'h0);
    evt_in = 8'h08;
    tick(); evt_in = '0;
    chk("t3_ovf1",   32'(out_ovf), 32'h1);
`ifdef LATCH_OVF_CNT_EN
    chk("t3_cnt",    32'(ovf_cnt), 32'h1);
`endif
    tick(); tick();
    chk("t3_hold_v", 32'(out_valid), 32'h1);
    chk("t3_hold_c", 32'(out_ch), 32'h3);
    out_ready = 1'b1;
    tick();
    chk("t3_clear",  32'(pending), 32'h0);
    chk("t3_ovfclr", 32'(out_ovf), 32'h0);

    // Handshake on ch 5 coinciding with a new ch 5 event (rr_ptr=4)
    out_ready = 1'b0; evt_in = 8'h22;
    tick(); evt_in = '0;
    tick();
    chk("t4_ch5",    32'(out_ch), 32'h5);
    out_ready = 1'b1; evt_in = 8'h20;
    tick(); evt_in = '0;
    chk("t4_keep",   32'(pending), 32'h22);
    chk("t4_idle",   32'(out_valid), 32'h0);
    tick();
    chk("t4_ch1",    32'(out_ch), 32'h1);
    tick(); tick();
    chk("t4_ch5b",   32'(out_ch), 32'h5);
    chk("t4_noovf",  32'(out_ovf), 32'h0);
`ifdef LATCH_OVF_CNT_EN
    chk("t4_cnt",    32'(ovf_cnt), 32'h1);
`endif
    tick();
    chk("t4_empty",  32'(pending), 32'h0);

    // arm=0 blocks sets; then reset mid-offer
    arm = 1'b0; evt_in = 8'hFF;
    tick(); tick();
    chk("t5_blocked", 32'(pending), 32'h0);
    chk("t5_novalid", 32'(out_valid), 32'h0);
    arm = 1'b1; out_ready = 1'b0;
    tick(); evt_in = '0;
    tick();
    chk("t5_offer",   32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_v",   32'(out_valid), 32'h0);
    chk("t5_rst_p",   32'(pending), 32'h0);
    chk("t5_rst_ch",  32'(out_ch), 32'h0);
    chk("t5_rst_ovf", 32'(out_ovf), 32'h0);
`ifdef LATCH_OVF_CNT_EN
    chk("t5_rst_cnt", 32'(ovf_cnt), 32'h0);
`endif
    evt_in = 8'hFF;
    tick();
    chk("t5_rst_hold", 32'(pending), 32'h0);
    evt_in = '0;
    rst_n = 1'b1;
    tick();
    chk("t5_release", 32'(out_valid), 32'h0);

`ifdef LATCH_OVF_CNT_EN
    // Counter accumulation, saturation and clear priority
    out_ready = 1'b0; evt_in = 8'h01;
    for (int c = 0; c < 11; c++) tick();
    chk("t6_cnt10",  32'(ovf_cnt), 32'd10);
    for (int c = 0; c < 290; c++) tick();
    chk("t6_sat",    32'(ovf_cnt), 32'd255);
    cnt_clr = 1'b1;
    tick();
    chk("t6_clrpri", 32'(ovf_cnt), 32'd0);
    cnt_clr = 1'b0;
    tick();
    chk("t6_inc1",   32'(ovf_cnt), 32'd1);
    evt_in = 8'hFF;
    tick();
    chk("t6_multi1", 32'(ovf_cnt), 32'd2);
    tick();
    chk("t6_multi8", 32'(ovf_cnt), 32'd10);
    evt_in = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
